// File: rtl/fifo_write_ctrl_if.sv
// Write-controller bus: write request/data, read acknowledge, storage taps and status.
// Latency: none, pure signal bundle.
// Backpressure: none here; full/wr_err report refused writes to the producer.
interface fifo_write_ctrl_if #(
  parameter int WIDTH = 32
);

  // Producer and read-side inputs to the controller
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_ack;

  // Storage register taps feeding the read-side 8:1 mux
  logic [WIDTH-1:0] to_reg0;
  logic [WIDTH-1:0] to_reg1;
  logic [WIDTH-1:0] to_reg2;
  logic [WIDTH-1:0] to_reg3;
  logic [WIDTH-1:0] to_reg4;
  logic [WIDTH-1:0] to_reg5;
  logic [WIDTH-1:0] to_reg6;
  logic [WIDTH-1:0] to_reg7;

  // Pointers, occupancy and registered write status
  logic [2:0]       rd_ptr;
  logic [2:0]       wr_ptr;
  logic [3:0]       count;
  logic             full;
  logic             empty;
  logic             wr_ack;
  logic             wr_err;

  // Side that issues writes and read acknowledges
  modport master (
    output wr_en, din, rd_ack,
    input  to_reg0, to_reg1, to_reg2, to_reg3,
    input  to_reg4, to_reg5, to_reg6, to_reg7,
    input  rd_ptr, wr_ptr, count, full, empty, wr_ack, wr_err
  );

  // The controller itself
  modport slave (
    input  wr_en, din, rd_ack,
    output to_reg0, to_reg1, to_reg2, to_reg3,
    output to_reg4, to_reg5, to_reg6, to_reg7,
    output rd_ptr, wr_ptr, count, full, empty, wr_ack, wr_err
  );

endinterface

// File: rtl/fifo_write_ctrl.sv
// Write side of an 8-entry register FIFO: storage, pointers, occupancy and write status.
// Latency: accepted data visible on to_regN one cycle after the write edge; wr_ack/wr_err one cycle after.
// Backpressure: writes while full are dropped and flagged with wr_err; reads while empty are ignored.
module fifo_write_ctrl #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset_n,
  fifo_write_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WR_ERROR = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] regs [8];
  logic [2:0]       wr_ptr_q;
  logic [2:0]       rd_ptr_q;
  logic [3:0]       count_q;

  logic             full_w;
  logic             empty_w;
  logic             wr_accept;
  logic             rd_accept;
  logic [7:0]       wr_sel;
  logic             wr_ack_w;
  logic             wr_err_w;

  // Flags come straight from the occupancy counter so they are exact in the same cycle.
  assign full_w    = (count_q == 4'd8);
  assign empty_w   = (count_q == 4'd0);

  // Both acceptance decisions use the pre-edge occupancy: a simultaneous read never
  // makes room for a write in the same cycle, and a simultaneous write never feeds a read.
  assign wr_accept = bus.wr_en  & ~full_w;
  assign rd_accept = bus.rd_ack & ~empty_w;

  // One-hot decode of the write pointer, gated by write acceptance
  always_comb begin
    wr_sel = 8'b0000_0000;
    if (wr_accept) begin
      case (wr_ptr_q)
        3'd0:    wr_sel = 8'b0000_0001;
        3'd1:    wr_sel = 8'b0000_0010;
        3'd2:    wr_sel = 8'b0000_0100;
        3'd3:    wr_sel = 8'b0000_1000;
        3'd4:    wr_sel = 8'b0001_0000;
        3'd5:    wr_sel = 8'b0010_0000;
        3'd6:    wr_sel = 8'b0100_0000;
        default: wr_sel = 8'b1000_0000;
      endcase
    end
  end

  // Storage: only the selected register loads; reads never disturb contents
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= bus.din;
        end
      end
    end
  end

  // Write pointer advances per accepted write, wrapping naturally at 3 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 3'd0;
    end else if (wr_accept) begin
      wr_ptr_q <= wr_ptr_q + 3'd1;
    end
  end

  // Read pointer advances per valid read acknowledge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= 3'd0;
    end else if (rd_accept) begin
      rd_ptr_q <= rd_ptr_q + 3'd1;
    end
  end

  // Occupancy: a write and a read in the same cycle cancel out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 4'd0;
    end else begin
      case ({wr_accept, rd_accept})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Status state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next status depends only on this cycle's request, never on the previous status
  always_comb begin
    state_nxt = IDLE;
    if (bus.wr_en) begin
      if (wr_accept) begin
        state_nxt = WRITE;
      end else begin
        state_nxt = WR_ERROR;
      end
    end
  end

  // Status outputs decoded from the registered state
  always_comb begin
    wr_ack_w = 1'b0;
    wr_err_w = 1'b0;
    case (state)
      WRITE:    wr_ack_w = 1'b1;
      WR_ERROR: wr_err_w = 1'b1;
      default: begin
        wr_ack_w = 1'b0;
        wr_err_w = 1'b0;
      end
    endcase
  end

  assign bus.wr_ack  = wr_ack_w;
  assign bus.wr_err  = wr_err_w;
  assign bus.full    = full_w;
  assign bus.empty   = empty_w;
  assign bus.count   = count_q;
  assign bus.wr_ptr  = wr_ptr_q;
  assign bus.rd_ptr  = rd_ptr_q;

  assign bus.to_reg0 = regs[0];
  assign bus.to_reg1 = regs[1];
  assign bus.to_reg2 = regs[2];
  assign bus.to_reg3 = regs[3];
  assign bus.to_reg4 = regs[4];
  assign bus.to_reg5 = regs[5];
  assign bus.to_reg6 = regs[6];
  assign bus.to_reg7 = regs[7];

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Bench for fifo_write_ctrl: directed steps push expected post-edge state into a scoreboard.
// Latency: a monitor pops one entry per falling edge after the step's rising edge.
// Backpressure: covers full rejection, empty reads, simultaneous read/write and async reset.
module tb_fifo_write_ctrl;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  fifo_write_ctrl_if #(.WIDTH(WIDTH)) bus ();

  fifo_write_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          tag;
    logic [3:0]  cnt;
    logic [2:0]  rp;
    logic [2:0]  wp;
    logic        ack;
    logic        err;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tag_n  = 0;

  function automatic logic [31:0] get_reg(input int i);
    case (i)
      0:       return bus.to_reg0;
      1:       return bus.to_reg1;
      2:       return bus.to_reg2;
      3:       return bus.to_reg3;
      4:       return bus.to_reg4;
      5:       return bus.to_reg5;
      6:       return bus.to_reg6;
      7:       return bus.to_reg7;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got 0x%08h, expected 0x%08h", name, tag, act, exp);
    end
  endtask

  // One directed vector: drive on the falling edge, record expectation after the rising edge
  task automatic step(input logic we, input logic ra, input logic [31:0] d,
                      input logic [3:0] c, input logic [2:0] rp, input logic [2:0] wp,
                      input logic ack, input logic err, input int idx, input logic [31:0] val);
    exp_t e;
    @(negedge clk);
    bus.wr_en  = we;
    bus.rd_ack = ra;
    bus.din    = d;
    @(posedge clk);
    e.tag = tag_n;
    e.cnt = c;
    e.rp  = rp;
    e.wp  = wp;
    e.ack = ack;
    e.err = err;
    e.idx = idx;
    e.val = val;
    tag_n++;
    sb.push_back(e);
  endtask

  // Idle a cycle with no requests so direct checks can run on a quiet bus
  task automatic settle();
    @(negedge clk);
    bus.wr_en  = 1'b0;
    bus.rd_ack = 1'b0;
    #1;
  endtask

  task automatic check_reset(input int tag);
    chk("rst_count",  tag, 32'(bus.count),  32'd0);
    chk("rst_rd_ptr", tag, 32'(bus.rd_ptr), 32'd0);
    chk("rst_wr_ptr", tag, 32'(bus.wr_ptr), 32'd0);
    chk("rst_full",   tag, 32'(bus.full),   32'd0);
    chk("rst_empty",  tag, 32'(bus.empty),  32'd1);
    chk("rst_wr_ack", tag, 32'(bus.wr_ack), 32'd0);
    chk("rst_wr_err", tag, 32'(bus.wr_err), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("rst_reg", tag, get_reg(i), 32'h0);
    end
  endtask

  // Drop reset between edges with a request pending, hold it across an edge, release
  task automatic pulse_reset(input int tag);
    @(negedge clk);
    bus.wr_en  = 1'b1;
    bus.rd_ack = 1'b1;
    bus.din    = 32'hFFFF_FFFF;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset(tag);
    @(posedge clk);
    #1;
    check_reset(tag + 1);
    @(negedge clk);
    bus.wr_en  = 1'b0;
    bus.rd_ack = 1'b0;
    reset_n    = 1'b1;
  endtask

  // Scoreboard monitor: compares the oldest expectation on each falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("count",  e.tag, 32'(bus.count),  32'(e.cnt));
        chk("rd_ptr", e.tag, 32'(bus.rd_ptr), 32'(e.rp));
        chk("wr_ptr", e.tag, 32'(bus.wr_ptr), 32'(e.wp));
        chk("wr_ack", e.tag, 32'(bus.wr_ack), 32'(e.ack));
        chk("wr_err", e.tag, 32'(bus.wr_err), 32'(e.err));
        chk("full",   e.tag, 32'(bus.full),   (e.cnt == 4'd8) ? 32'd1 : 32'd0);
        chk("empty",  e.tag, 32'(bus.empty),  (e.cnt == 4'd0) ? 32'd1 : 32'd0);
        if (e.idx >= 0) begin
          chk("to_reg", e.tag, get_reg(e.idx), e.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.wr_en  = 1'b0;
    bus.rd_ack = 1'b0;
    bus.din    = 32'h0;
    reset_n    = 1'b1;
    #1;
    reset_n    = 1'b0;
    #2;
    check_reset(1000);
    @(negedge clk);
    reset_n = 1'b1;

    // Fill: eight writes land in reg0..7 in order, wr_ptr wraps to 0
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32'h1111_1111 * (i + 1), 4'(i + 1), 3'd0, 3'(i + 1),
           1'b1, 1'b0, i, 32'h1111_1111 * (i + 1));
    end
    settle();
    for (int i = 0; i < 8; i++) begin
      chk("fill_reg", 2000 + i, get_reg(i), 32'h1111_1111 * (i + 1));
    end

    // Write while full is rejected, storage untouched
    step(1'b1, 1'b0, 32'hDEAD_BEEF, 4'd8, 3'd0, 3'd0, 1'b0, 1'b1, 0, 32'h1111_1111);

    // Full plus simultaneous read: write refused, read taken; then both succeed
    step(1'b1, 1'b1, 32'hCAFE_F00D, 4'd7, 3'd1, 3'd0, 1'b0, 1'b1, 0, 32'h1111_1111);
    step(1'b1, 1'b1, 32'h0BAD_C0DE, 4'd7, 3'd2, 3'd1, 1'b1, 1'b0, 0, 32'h0BAD_C0DE);

    // Drain seven entries; rd_ptr wraps 7 -> 0 -> 1
    for (int j = 0; j < 7; j++) begin
      step(1'b0, 1'b1, 32'h0, 4'(6 - j), 3'(3 + j), 3'd1, 1'b0, 1'b0, -1, 32'h0);
    end
    // Read on empty is ignored; reads leave storage intact
    step(1'b0, 1'b1, 32'h0, 4'd0, 3'd1, 3'd1, 1'b0, 1'b0, 1, 32'h2222_2222);

    pulse_reset(3000);

    // From empty: lone read ignored, then read+write accepts only the write
    step(1'b0, 1'b1, 32'h0,         4'd0, 3'd0, 3'd0, 1'b0, 1'b0, -1, 32'h0);
    step(1'b1, 1'b1, 32'hA5A5_A5A5, 4'd1, 3'd0, 3'd1, 1'b1, 1'b0, 0, 32'hA5A5_A5A5);

    pulse_reset(4000);

    // Wrap: 8 writes, 8 reads, 3 writes
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32'hA000_0000 + i, 4'(i + 1), 3'd0, 3'(i + 1),
           1'b1, 1'b0, i, 32'hA000_0000 + i);
    end
    for (int j = 0; j < 8; j++) begin
      step(1'b0, 1'b1, 32'h0, 4'(7 - j), 3'(j + 1), 3'd0, 1'b0, 1'b0, -1, 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'hB000_0000 + k, 4'(k + 1), 3'd0, 3'(k + 1),
           1'b1, 1'b0, k, 32'hB000_0000 + k);
    end
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("wrap_new", 5000 + i, get_reg(i), 32'hB000_0000 + i);
    end
    for (int i = 3; i < 8; i++) begin
      chk("wrap_old", 5000 + i, get_reg(i), 32'hA000_0000 + i);
    end

    // Bring occupancy to 5, then reset between edges
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, 32'hC000_0003 + k, 4'(4 + k), 3'd0, 3'(4 + k),
           1'b1, 1'b0, 3 + k, 32'hC000_0003 + k);
    end
    pulse_reset(6000);

    // First edge after release behaves as from empty
    step(1'b1, 1'b0, 32'h0000_0077, 4'd1, 3'd0, 3'd1, 1'b1, 1'b0, 0, 32'h0000_0077);
    settle();
    chk("sb_drain", 7000, 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_ctrl.md
FIFO_WRITE_CTRL -- requirements
Module: fifo_write_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, data word width of every storage register.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: wr_en  input  1  write request for din this cycle.
REQ-005 SHALL have port: din  input  WIDTH  write data.
REQ-006 SHALL have port: rd_ack  input  1  read side consumed the entry at rd_ptr this cycle.
REQ-007 SHALL have ports: to_reg0 .. to_reg7  output  WIDTH each  storage register contents, feeding the read-side 8:1 mux data inputs.
REQ-008 SHALL have port: rd_ptr  output  3  read address, drives the read-side mux select.
REQ-009 SHALL have port: wr_ptr  output  3  next storage register to be written.
REQ-010 SHALL have port: count  output  4  occupancy, 0..8.
REQ-011 SHALL have ports: full, empty  output  1 each  occupancy flags.
REQ-012 SHALL have ports: wr_ack, wr_err  output  1 each  registered write status.

Function
REQ-013 SHALL hold 8 storage registers of WIDTH bits; register N drives to_regN directly.
REQ-014 SHALL accept a write on a rising edge when wr_en=1 and count<8 (count sampled before the edge); accepted din lands in register wr_ptr, visible on to_reg[wr_ptr] the following cycle.
REQ-015 SHALL select the written register by a 3-to-8 one-hot decode of wr_ptr; only that register changes.
REQ-016 SHALL advance wr_ptr by 1 modulo 8 per accepted write (7 -> 0 wrap).
REQ-017 SHALL advance rd_ptr by 1 modulo 8 on rd_ack=1 when count>0; rd_ack with count=0 ignored, no change.
REQ-018 SHALL update count: +1 on accepted write only, -1 on valid rd_ack only, unchanged when both or neither occur.
REQ-019 SHALL, on wr_en=1 and rd_ack=1 with count=8, reject the write (full judged pre-edge) and perform the read; count -> 7.
REQ-020 SHALL, on wr_en=1 and rd_ack=1 with count=0, accept the write and ignore the read; count -> 1.
REQ-021 SHALL drive full=1 exactly when count=8 and empty=1 exactly when count=0, both decoded combinationally from count.
REQ-022 SHALL implement FSM states IDLE, WRITE, WR_ERROR, updated every edge: wr_en=0 -> IDLE; wr_en=1 and accepted -> WRITE; wr_en=1 and rejected -> WR_ERROR; state independent of previous state.
REQ-023 SHALL drive wr_ack=1 only in WRITE and wr_err=1 only in WR_ERROR, i.e. one cycle after the request edge; back-to-back requests give back-to-back status.
REQ-024 SHALL leave storage, wr_ptr and count unchanged on a rejected write.
REQ-025 SHALL leave storage untouched by reads; contents persist until overwritten.

Reset
REQ-026 SHALL, on reset_n=0, immediately (no clock) clear all storage to 0, wr_ptr=0, rd_ptr=0, count=0, state IDLE, giving empty=1, full=0, wr_ack=0, wr_err=0.
REQ-027 SHALL hold reset values while reset_n=0 regardless of wr_en/rd_ack; reset mid-write discards the write, and the first edge after release behaves as from empty.

Verification
REQ-028 SHALL cover: reset, then 8 writes din=0x11111111..0x88888888 -> to_reg0..7 match in order, count=8, full=1, wr_ack high 8 cycles, wr_ptr=0.
REQ-029 SHALL cover: 9th write when full, din=0xDEADBEEF -> wr_err=1 next cycle, to_reg0 still 0x11111111, count=8.
REQ-030 SHALL cover: from full, wr_en=1 and rd_ack=1 together -> write rejected, wr_err=1, rd_ptr 0->1, count=7; next simultaneous pair -> write to reg0, count=7, rd_ptr=2.
REQ-031 SHALL cover: from empty, rd_ack=1 alone -> rd_ptr=0, count=0, empty=1; rd_ack+wr_en din=0xA5A5A5A5 -> to_reg0=0xA5A5A5A5, count=1, rd_ptr=0.
REQ-032 SHALL cover: wrap -- 8 writes, 8 reads, 3 writes -> wr_ptr=3, rd_ptr=0 after reads advance it 8 times, count=3, to_reg0..2 new data, to_reg3..7 old data.
REQ-033 SHALL cover: reset_n pulsed low between clock edges with count=5 -> all outputs at reset values before next edge, storage all 0.
